serial_link_flit_deser: RTL and testbench

Receive-side flit reassembler for the serial link data-link layer: the counterpart of the transmit-side flit serializer. It accepts fixed-width link beats (already synchronized into the link clock domain by the physical layer) and reassembles them into one flit for the network-layer output. Each packet is one header beat carrying a payload length, followed by that many payload beats. Every flit released downstream produces one credit pulse, which the link returns to the remote transmitter.

---
 rtl/serial_link_flit_deser.sv | 162 ++++++++++++++++
 tb/tb_serial_link_flit_deser.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_link_flit_deser.sv
// ---------------------------------------------------------------------------
// serial_link_flit_deser
//
// Receive-side flit reassembler for the serial link data-link layer.
// Link beats arrive as packets: one header beat whose low LenWidth bits give
// the payload length, followed by that many payload beats. The payload beats
// are packed into one flit (beat k at bits [k*BeatWidth +: BeatWidth]) and
// held until the network layer takes it. Each consumed flit produces a
// one-cycle credit pulse that the link returns to the remote transmitter.
// Headers with a zero or oversized length are dropped and flagged.
//
// Ports:
//   clk_i         link clock (only clock)
//   rst_i         asynchronous active-high reset
//   beat_valid_i  input beat present
//   beat_ready_o  block accepts the input beat (depends on state only)
//   beat_data_i   beat payload / header
//   flit_valid_o  reassembled flit present (depends on state only)
//   flit_ready_i  downstream accepts the flit
//   flit_data_o   reassembled flit, unused upper slots read as zero
//   flit_len_o    number of valid payload beats in flit_data_o
//   credit_o      one-cycle pulse after each flit handshake
//   err_len_o     one-cycle pulse after each rejected header
//   busy_o        high whenever a packet is being collected or held
// ---------------------------------------------------------------------------
module serial_link_flit_deser #(
  parameter int BeatWidth = 16,
  parameter int FlitWidth = 64,
  parameter int NumBeats  = FlitWidth / BeatWidth,
  parameter int LenWidth  = $clog2(NumBeats + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 beat_valid_i,
  output logic                 beat_ready_o,
  input  logic [BeatWidth-1:0] beat_data_i,
  output logic                 flit_valid_o,
  input  logic                 flit_ready_i,
  output logic [FlitWidth-1:0] flit_data_o,
  output logic [LenWidth-1:0]  flit_len_o,
  output logic                 credit_o,
  output logic                 err_len_o,
  output logic                 busy_o
);

  // Parameter sanity: the flit must hold a whole number of beats, and the
  // length field must fit inside one header beat.
  if ((FlitWidth % BeatWidth) != 0) begin : g_bad_flit_width
    $error("serial_link_flit_deser: FlitWidth must be a multiple of BeatWidth");
  end
  if (LenWidth > BeatWidth) begin : g_bad_len_width
    $error("serial_link_flit_deser: length field wider than a beat");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [FlitWidth-1:0] data_q, data_d;
  logic [LenWidth-1:0]  len_q, len_d;
  logic [LenWidth-1:0]  cnt_q, cnt_d;
  logic                 credit_q, credit_d;
  logic                 err_q, err_d;

  logic [LenWidth-1:0]  hdr_len;
  logic                 hdr_ok;
  logic                 last_beat;

  // Header decode; the upper header bits carry nothing for this block.
  always_comb begin
    hdr_len   = beat_data_i[LenWidth-1:0];
    hdr_ok    = (hdr_len != '0) && (hdr_len <= LenWidth'(NumBeats));
    last_beat = (cnt_q == (len_q - LenWidth'(1)));
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    credit_d = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (beat_valid_i) begin
          if (hdr_ok) begin
            // Clearing here is what makes slots beyond len read as zero,
            // since only slots below len are written afterwards.
            data_d  = '0;
            len_d   = hdr_len;
            cnt_d   = '0;
            state_d = COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      COLLECT: begin
        if (beat_valid_i) begin
          for (int k = 0; k < NumBeats; k++) begin
            if (cnt_q == LenWidth'(k)) begin
              data_d[k*BeatWidth +: BeatWidth] = beat_data_i;
            end
          end
          // cnt reaches at most NumBeats, which always fits in LenWidth.
          cnt_d = cnt_q + LenWidth'(1);
          if (last_beat) begin
            state_d = HOLD;
          end
        end
      end

      HOLD: begin
        if (flit_ready_i) begin
          credit_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      data_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      credit_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      credit_q <= credit_d;
      err_q    <= err_d;
    end
  end

  // Handshake outputs come straight from the state register, so there is no
  // combinational path between the two sides of the block.
  always_comb begin
    beat_ready_o = (state_q != HOLD);
    flit_valid_o = (state_q == HOLD);
    busy_o       = (state_q != IDLE);
    flit_data_o  = data_q;
    flit_len_o   = len_q;
    credit_o     = credit_q;
    err_len_o    = err_q;
  end

endmodule

// File: tb/tb_serial_link_flit_deser.sv
module tb_serial_link_flit_deser;

  localparam int BW = 16;
  localparam int FW = 64;
  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          rst_i;
  logic          beat_valid_i;
  logic          beat_ready_o;
  logic [BW-1:0] beat_data_i;
  logic          flit_valid_o;
  logic          flit_ready_i;
  logic [FW-1:0] flit_data_o;
  logic [LW-1:0] flit_len_o;
  logic          credit_o;
  logic          err_len_o;
  logic          busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_link_flit_deser #(
    .BeatWidth(BW),
    .FlitWidth(FW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .beat_valid_i (beat_valid_i),
    .beat_ready_o (beat_ready_o),
    .beat_data_i  (beat_data_i),
    .flit_valid_o (flit_valid_o),
    .flit_ready_i (flit_ready_i),
    .flit_data_o  (flit_data_o),
    .flit_len_o   (flit_len_o),
    .credit_o     (credit_o),
    .err_len_o    (err_len_o),
    .busy_o       (busy_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the flit is the payload with everything above len beats masked off.
  function automatic logic [63:0] model_flit(input logic [15:0] hdr, input logic [63:0] pl);
    int          len;
    logic [64:0] lim;
    len = int'(hdr[2:0]);
    lim = 65'd1 << (16 * len);
    return pl & (lim[63:0] - 64'd1 + {63'd0, lim[64]} * 64'd0) | (lim[64] ? pl : 64'd0);
  endfunction

  // Sends one packet (header plus payload beats taken from pl, low beat first),
  // optionally with idle gaps between payload beats and a downstream stall.
  task automatic do_packet(input logic [15:0] hdr, input logic [63:0] pl,
                           input int gap, input int stall);
    int          len;
    bit          ok;
    logic [63:0] exp;
    len = int'(hdr[2:0]);
    ok  = (len >= 1) && (len <= 4);
    exp = model_flit(hdr, pl);

    beat_valid_i = 1'b1;
    beat_data_i  = hdr;
    chk("hdr_ready", beat_ready_o, 1);
    step();
    beat_valid_i = 1'b0;

    if (!ok) begin
      chk("err_pulse", err_len_o, 1);
      chk("err_busy", busy_o, 0);
      chk("err_novalid", flit_valid_o, 0);
      step();
      chk("err_once", err_len_o, 0);
      return;
    end

    chk("busy_collect", busy_o, 1);
    chk("no_err_good_hdr", err_len_o, 0);
    for (int k = 0; k < len; k++) begin
      for (int g = 0; g < gap; g++) begin
        step();
        chk("gap_novalid", flit_valid_o, 0);
      end
      beat_valid_i = 1'b1;
      beat_data_i  = pl[k*16 +: 16];
      chk("collect_ready", beat_ready_o, 1);
      step();
      beat_valid_i = 1'b0;
    end

    chk("flit_valid", flit_valid_o, 1);
    chk("flit_data", flit_data_o, exp);
    chk("flit_len", flit_len_o, 64'(len));
    chk("hold_ready", beat_ready_o, 0);

    for (int s = 0; s < stall; s++) begin
      step();
      chk("stall_valid", flit_valid_o, 1);
      chk("stall_data", flit_data_o, exp);
      chk("stall_credit", credit_o, 0);
    end

    flit_ready_i = 1'b1;
    step();
    flit_ready_i = 1'b0;
    chk("credit", credit_o, 1);
    chk("post_valid", flit_valid_o, 0);
    chk("post_busy", busy_o, 0);
    step();
    chk("credit_once", credit_o, 0);
  endtask

  initial begin
    logic [63:0] held;

    rst_i        = 1'b1;
    beat_valid_i = 1'b0;
    beat_data_i  = '0;
    flit_ready_i = 1'b0;
    step();
    step();

    // Reset values.
    chk("rst_beat_ready", beat_ready_o, 1);
    chk("rst_flit_valid", flit_valid_o, 0);
    chk("rst_flit_data", flit_data_o, 0);
    chk("rst_flit_len", flit_len_o, 0);
    chk("rst_credit", credit_o, 0);
    chk("rst_err", err_len_o, 0);
    chk("rst_busy", busy_o, 0);
    rst_i = 1'b0;
    step();

    // Full flit, then a short flit whose stale upper slots must be cleared.
    do_packet(16'h0004, 64'h4444_3333_2222_1111, 0, 0);
    chk("full_data_const", model_flit(16'h0004, 64'h4444_3333_2222_1111) ^ flit_data_o, 64'd0);
    do_packet(16'hFF02, 64'hDEAD_BEEF_BBBB_AAAA, 0, 0);
    chk("short_data_const", flit_data_o, 64'h0000_0000_BBBB_AAAA);

    // Back-to-back bad headers.
    beat_valid_i = 1'b1;
    beat_data_i  = 16'h0000;
    step();
    chk("bad0_err", err_len_o, 1);
    chk("bad0_busy", busy_o, 0);
    beat_data_i = 16'h0005;
    step();
    chk("bad5_err", err_len_o, 1);
    chk("bad5_busy", busy_o, 0);
    chk("bad5_novalid", flit_valid_o, 0);
    beat_valid_i = 1'b0;
    step();
    chk("bad_err_clear", err_len_o, 0);
    do_packet(16'h0001, 64'h0000_0000_0000_CAFE, 0, 0);

    // Backpressure with a new header waiting at the input.
    beat_valid_i = 1'b1;
    beat_data_i  = 16'h0003;
    step();
    beat_data_i = 16'h0101;
    step();
    beat_data_i = 16'h0202;
    step();
    beat_data_i = 16'h0303;
    step();
    beat_data_i = 16'h0002;
    chk("bp_valid", flit_valid_o, 1);
    chk("bp_data0", flit_data_o, 64'h0000_0303_0202_0101);
    held = flit_data_o;
    for (int s = 0; s < 10; s++) begin
      step();
      chk("bp_ready_low", beat_ready_o, 0);
      chk("bp_data_stable", flit_data_o, held);
      chk("bp_no_credit", credit_o, 0);
    end
    flit_ready_i = 1'b1;
    step();
    flit_ready_i = 1'b0;
    chk("bp_credit", credit_o, 1);
    chk("bp_idle_ready", beat_ready_o, 1);
    chk("bp_idle_busy", busy_o, 0);
    step();
    chk("bp_hdr_taken", busy_o, 1);
    chk("bp_credit_once", credit_o, 0);
    beat_data_i = 16'h0A0A;
    step();
    beat_data_i = 16'h0B0B;
    step();
    beat_valid_i = 1'b0;
    chk("bp2_valid", flit_valid_o, 1);
    chk("bp2_data", flit_data_o, 64'h0000_0000_0B0B_0A0A);
    chk("bp2_len", flit_len_o, 2);
    flit_ready_i = 1'b1;
    step();
    flit_ready_i = 1'b0;
    chk("bp2_credit", credit_o, 1);
    step();

    // Gapped input.
    do_packet(16'h0003, 64'h0000_9999_8888_7777, 2, 0);

    // Reset in the middle of collecting a four-beat flit.
    beat_valid_i = 1'b1;
    beat_data_i  = 16'h0004;
    step();
    beat_data_i = 16'h1234;
    step();
    beat_data_i = 16'h5678;
    step();
    beat_valid_i = 1'b0;
    chk("mid_busy", busy_o, 1);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_ready", beat_ready_o, 1);
    chk("mid_rst_data", flit_data_o, 0);
    chk("mid_rst_len", flit_len_o, 0);
    chk("mid_rst_valid", flit_valid_o, 0);
    step();
    rst_i = 1'b0;
    chk("mid_rst_credit", credit_o, 0);
    step();
    chk("mid_after_credit", credit_o, 0);
    do_packet(16'h0001, 64'h0000_0000_0000_5A5A, 0, 0);

    // Randomized packets, including bad lengths, gaps and stalls.
    for (int i = 0; i < 30; i++) begin
      logic [15:0] hdr;
      logic [63:0] pl;
      hdr = 16'($urandom);
      pl  = {$urandom, $urandom};
      do_packet(hdr, pl, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
